// File: rtl/mul_add_pkg.sv
// Shared definitions for the sequential multiply-add block.
// Holds the FSM state encoding and the default operand widths.
// Latency/backpressure: n/a (types and constants only).
package mul_add_pkg;

  // Default multiplier (merchant) and multiplicand (divisor) widths.
  localparam int DEF_N = 5;
  localparam int DEF_M = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mul_add_pkg

// File: rtl/mul_add_seq.sv
// Sequential shift-add unit: product = merchant*divisor + remainder (unsigned, N+M bits).
// Latency: rdy pulses N+1 edges after the accepting edge (earlier for small merchant with
//   MUL_ADD_SEQ_EARLY_EXIT_EN defined: RUN ends once the shifted multiplier is zero).
// Backpressure: none queued; data_rdy is ignored while busy=1, so hold it until busy=0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, highest priority
//   data_rdy   start request, operands sampled in the same cycle when idle
//   merchant   N-bit multiplier (quotient)
//   divisor    M-bit multiplicand
//   remainder  M-bit addend, preloaded into the accumulator
//   busy       high in RUN and DONE
//   rdy        one-cycle pulse, product valid
//   product    N+M-bit result, held until the next completion
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_rdy,
  input  logic [N-1:0]     merchant,
  input  logic [M-1:0]     divisor,
  input  logic [M-1:0]     remainder,
  output logic             busy,
  output logic             rdy,
  output logic [N+M-1:0]   product
);

  localparam int W  = N + M;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    mplier;
  logic [W-1:0]    mcand;
  logic [W-1:0]    acc;
  logic [CW-1:0]   step;
  logic            run_last;

`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
  // Once the multiplier shifted this cycle has no set bits left, further
  // RUN cycles could only add zero, so finish now.
  assign run_last = (step == LAST_STEP) || ((mplier >> 1) == '0);
`else
  assign run_last = (step == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_rdy) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      step    <= '0;
      rdy     <= 1'b0;
      product <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (data_rdy) begin
            mplier <= merchant;
            mcand  <= {{N{1'b0}}, divisor};
            acc    <= {{N{1'b0}}, remainder};
            step   <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          step   <= step + CW'(1);
        end
        DONE: begin
          product <= acc;
          rdy     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : mul_add_seq

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq (N=5, M=3): directed vector table plus
// hand-written sequences for ignored starts and mid-operation reset.
module tb_mul_add_seq;

  localparam int N = 5;
  localparam int M = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           data_rdy;
  logic [N-1:0]   merchant;
  logic [M-1:0]   divisor;
  logic [M-1:0]   remainder;
  logic           busy;
  logic           rdy;
  logic [N+M-1:0] product;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0]   m;
    logic [M-1:0]   d;
    logic [M-1:0]   r;
    logic [N+M-1:0] p;
  } vec_t;

  vec_t vecs[8];

  mul_add_seq #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_rdy  (data_rdy),
    .merchant  (merchant),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .rdy       (rdy),
    .product   (product)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Edges from the accepting edge to the edge that raises rdy.
  function automatic int exp_lat(input logic [N-1:0] m);
`ifdef MUL_ADD_SEQ_EARLY_EXIT_EN
    int idx = 0;
    for (int i = 0; i < N; i++) if (m[i]) idx = i;
    return idx + 2;
`else
    return N + 1;
`endif
  endfunction

  // Present operands for one cycle; the next edge accepts them.
  task automatic go(input string name, input logic [N-1:0] m, input logic [M-1:0] d,
                    input logic [M-1:0] r);
    merchant  = m;
    divisor   = d;
    remainder = r;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    chk({name, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({name, "_rdy_after_accept"}, 32'(rdy), 32'd0);
  endtask

  task automatic wait_done(input string name, input logic [N+M-1:0] exp_p, input int lat);
    int edges = 0;
    bit busy_ok = 1'b1;
    while (!rdy && edges < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      edges++;
    end
    chk({name, "_rdy_seen"}, 32'(rdy), 32'd1);
    chk({name, "_latency"}, 32'(edges), 32'(lat));
    chk({name, "_product"}, 32'(product), 32'(exp_p));
    chk({name, "_busy_while_running"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    bit extra;

    vecs[0] = '{m: 5'd13, d: 3'd5, r: 3'd3, p: 8'd68};
    vecs[1] = '{m: 5'd31, d: 3'd7, r: 3'd6, p: 8'd223};
    vecs[2] = '{m: 5'd0,  d: 3'd7, r: 3'd5, p: 8'd5};
    vecs[3] = '{m: 5'd6,  d: 3'd2, r: 3'd0, p: 8'd12};
    vecs[4] = '{m: 5'd1,  d: 3'd1, r: 3'd1, p: 8'd2};
    vecs[5] = '{m: 5'd31, d: 3'd0, r: 3'd7, p: 8'd7};
    vecs[6] = '{m: 5'd16, d: 3'd7, r: 3'd7, p: 8'd119};
    vecs[7] = '{m: 5'd2,  d: 3'd3, r: 3'd1, p: 8'd7};

    rst       = 1'b1;
    data_rdy  = 1'b0;
    merchant  = '0;
    divisor   = '0;
    remainder = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_product", 32'(product), 32'd0);

    // First accept on the edge right after reset release, then every
    // following operation starts on the edge that ends the previous rdy cycle.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      go($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].r);
      wait_done($sformatf("vec%0d", i), vecs[i].p, exp_lat(vecs[i].m));
    end
    tick();
    chk("last_rdy_single_pulse", 32'(rdy), 32'd0);
    chk("last_idle", 32'(busy), 32'd0);
    repeat (3) tick();

    // Start request while busy must be dropped.
    go("ign", 5'd13, 3'd5, 3'd3);
    tick();
    merchant  = 5'd1;
    divisor   = 3'd1;
    remainder = 3'd1;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    wait_done("ign", 8'd68, exp_lat(5'd13) - 2);
    extra = 1'b0;
    repeat (12) begin
      tick();
      if (rdy) extra = 1'b1;
    end
    chk("ign_no_second_rdy", 32'(extra), 32'd0);
    chk("ign_product_hold", 32'(product), 32'd68);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset in the third RUN cycle aborts without a rdy pulse.
    go("abort", 5'd31, 3'd7, 3'd6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    rst = 1'b0;
    go("post_abort", 5'd2, 3'd3, 3'd1);
    wait_done("post_abort", 8'd7, exp_lat(5'd2));
    tick();
    chk("post_abort_rdy_single_pulse", 32'(rdy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mul_add_seq
